// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between the icache refill
// path and the data path, one transaction at a time, with a per-transaction timeout.
module mem_arbiter #(
  parameter int N       = 64,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  input  logic          i_abort,
  output logic [AW-1:0] i_rdata,
  output logic          i_val,
  input  logic          d_req,
  input  logic [1:0]    d_we,
  input  logic [N-1:0]  d_adr,
  input  logic [N-1:0]  d_wdata,
  output logic [N-1:0]  d_rdata,
  output logic          d_val,
  output logic          m_req,
  output logic [1:0]    m_we,
  output logic [N-1:0]  m_adr,
  output logic [N-1:0]  m_wdata,
  input  logic [N-1:0]  m_rdata,
  input  logic          m_val,
  output logic          owner,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t         state_q, state_d;
  logic           m_req_q, m_req_d;
  logic [1:0]     m_we_q, m_we_d;
  logic [N-1:0]   m_adr_q, m_adr_d;
  logic [N-1:0]   m_wdata_q, m_wdata_d;
  logic           owner_q, owner_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           last_d_q, last_d_d;
  logic           squash_q, squash_d;
  logic [3:0]     timer_q, timer_d;

  logic [N-1:0]   i_adr_ext;
  logic           i_ok;
  logic           grant_i;
  logic           grant_d;
  logic           expired;

  always_comb begin
    i_adr_ext          = '0;
    i_adr_ext[AW-1:0]  = i_adr;
    // An aborting icache cannot win a grant; on a tie the side not served last wins.
    i_ok     = i_req & ~i_abort;
    grant_i  = i_ok & (~d_req | last_d_q);
    grant_d  = d_req & ~grant_i;
    expired  = (timer_q == 4'(TIMEOUT - 1));

    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_wdata_d = m_wdata_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    last_d_d  = last_d_q;
    squash_d  = squash_q;
    timer_d   = timer_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d   = WAIT_I;
          m_adr_d   = i_adr_ext;
          m_we_d    = 2'b00;
          m_wdata_d = '0;
          owner_d   = 1'b0;
          last_d_d  = 1'b0;
        end else if (grant_d) begin
          state_d   = WAIT_D;
          m_adr_d   = d_adr;
          m_we_d    = d_we;
          m_wdata_d = d_wdata;
          owner_d   = 1'b1;
          last_d_d  = 1'b1;
        end
        if (grant_i || grant_d) begin
          m_req_d  = 1'b1;
          busy_d   = 1'b1;
          squash_d = 1'b0;
          timer_d  = '0;
        end
      end
      WAIT_I, WAIT_D: begin
        if (state_q == WAIT_I && i_abort) squash_d = 1'b1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (m_val) begin
          m_req_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (expired) begin
          err_d   = 1'b1;
          m_req_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 2'b00;
      m_adr_q   <= '0;
      m_wdata_q <= '0;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      last_d_q  <= 1'b1;
      squash_q  <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_wdata_q <= m_wdata_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      last_d_q  <= last_d_d;
      squash_q  <= squash_d;
      timer_q   <= timer_d;
    end
  end

  // Completion is forwarded in the m_val cycle itself to save a cycle of latency.
  assign i_val   = (state_q == WAIT_I) & m_val & ~squash_q;
  assign d_val   = (state_q == WAIT_D) & m_val;
  assign i_rdata = i_val ? m_rdata[AW-1:0] : '0;
  assign d_rdata = d_val ? m_rdata : '0;

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_adr   = m_adr_q;
  assign m_wdata = m_wdata_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
